// File: rtl/pwm_generator_multi.sv
// Multi-channel PWM with one shared period counter and double-buffered config.
// Optional per-channel phase offset is enabled by defining PWM_PHASE_EN.
module pwm_generator_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      oneshot,
  input  logic                      start,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
`ifdef PWM_PHASE_EN
  input  logic [CHANNELS*WIDTH-1:0] phase,
`endif
  input  logic                      cfg_load,
  output logic [CHANNELS-1:0]       pulse,
  output logic                      period_done,
  output logic                      busy
);

  localparam int CW = CHANNELS * WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    p_pend_q, p_act_q;
  logic [WIDTH-1:0]    p_last;
  logic [CW-1:0]       d_pend_q, d_act_q;
  logic                pend_vld_q;
  logic [CHANNELS-1:0] hit, pulse_d;
  logic                done_d;
  logic                running;
  logic                p_zero;
  logic                wrap;
  logic                bypass;
  logic                copy;

  assign running = (state_q == RUN);
  assign p_zero  = (p_act_q == '0);
  assign p_last  = p_act_q - WIDTH'(1);
  assign wrap    = running && enable && !p_zero
                   && (cnt_q == p_last);
  assign bypass  = wrap && cfg_load;
  // Pending set is promoted when idle, at a wrap, or when P=0 stalls the count
  assign copy    = pend_vld_q && !bypass
                   && (!running || wrap || p_zero);
  assign busy    = running;

`ifdef PWM_PHASE_EN
  logic [CW-1:0]           ph_pend_q, ph_act_q;
  logic [CW-1:0]           ph_eff;
  logic [CHANNELS*(WIDTH+1)-1:0] shift;

  always_comb begin
    hit    = '0;
    ph_eff = '0;
    shift  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ph_eff[i*WIDTH +: WIDTH] = ph_act_q[i*WIDTH +: WIDTH];
      if (ph_act_q[i*WIDTH +: WIDTH] >= p_act_q)
        ph_eff[i*WIDTH +: WIDTH] = '0;
      // Widened by one bit so counter+P never overflows
      if (cnt_q >= ph_eff[i*WIDTH +: WIDTH])
        shift[i*(WIDTH+1) +: WIDTH+1] =
          {1'b0, cnt_q - ph_eff[i*WIDTH +: WIDTH]};
      else
        shift[i*(WIDTH+1) +: WIDTH+1] =
          {1'b0, cnt_q} + {1'b0, p_act_q}
          - {1'b0, ph_eff[i*WIDTH +: WIDTH]};
      hit[i] = shift[i*(WIDTH+1) +: WIDTH+1]
               < {1'b0, d_act_q[i*WIDTH +: WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_pend_q <= '0;
      ph_act_q  <= '0;
    end else begin
      if (cfg_load)
        ph_pend_q <= phase;
      if (bypass)
        ph_act_q <= phase;
      else if (copy)
        ph_act_q <= ph_pend_q;
    end
  end
`else
  always_comb begin
    hit = '0;
    for (int i = 0; i < CHANNELS; i++)
      hit[i] = cnt_q < d_act_q[i*WIDTH +: WIDTH];
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable && (!oneshot || start))
          state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (p_zero) begin
          cnt_d = '0;
        end else if (wrap) begin
          cnt_d  = '0;
          done_d = 1'b1;
          // One-shot leaves RUN here; outputs stay low while idle
          if (oneshot)
            state_d = IDLE;
          else
            pulse_d = hit;
        end else begin
          cnt_d   = cnt_q + WIDTH'(1);
          pulse_d = hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pulse       <= '0;
      period_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse       <= pulse_d;
      period_done <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_pend_q   <= '0;
      d_pend_q   <= '0;
      p_act_q    <= '0;
      d_act_q    <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      if (cfg_load) begin
        p_pend_q <= period;
        d_pend_q <= duty;
      end
      if (bypass) begin
        p_act_q <= period;
        d_act_q <= duty;
      end else if (copy) begin
        p_act_q <= p_pend_q;
        d_act_q <= d_pend_q;
      end
      pend_vld_q <= cfg_load ? !bypass
                             : (pend_vld_q && !copy);
    end
  end

endmodule

// File: tb/tb_pwm_generator_multi.sv
// Self-checking bench for pwm_generator_multi: directed scenarios
// plus randomized continuous runs with mid-run reconfiguration.
module tb_pwm_generator_multi;

  localparam int W  = 8;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          oneshot = 1'b0;
  logic          start = 1'b0;
  logic          cfg_load = 1'b0;
  logic [W-1:0]  period = '0;
  logic [CH*W-1:0] duty = '0;
  logic [CH*W-1:0] phase = '0;
  logic [CH-1:0] pulse;
  logic          period_done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model: active/pending settings and expected counter
  int rp, rc, pp, pv;
  int rd[CH];
  int pd[CH];

  always #5 clk = ~clk;

  pwm_generator_multi #(
    .WIDTH(W),
    .CHANNELS(CH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .oneshot(oneshot),
    .start(start),
    .period(period),
    .duty(duty),
`ifdef PWM_PHASE_EN
    .phase(phase),
`endif
    .cfg_load(cfg_load),
    .pulse(pulse),
    .period_done(period_done),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int p, input int d0, input int d1,
                         input int d2, input int d3);
    period = W'(p);
    duty   = {W'(d3), W'(d2), W'(d1), W'(d0)};
  endtask

  function automatic logic [CH-1:0] exp_pulse();
    logic [CH-1:0] e;
    e = '0;
    for (int i = 0; i < CH; i++)
      e[i] = (rp != 0) && (rc < rd[i]);
    return e;
  endfunction

  // Load a configuration while idle; it is active two edges later
  task automatic idle_load(input int p, input int d0, input int d1,
                           input int d2, input int d3);
    set_cfg(p, d0, d1, d2, d3);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    tick();
    rp = p;
    rd[0] = d0; rd[1] = d1; rd[2] = d2; rd[3] = d3;
    pv = 0;
    rc = 0;
  endtask

  task automatic start_run(input string tag);
    enable = 1'b1;
    tick();
    chk({tag, "_entry_busy"}, busy, 1);
    chk({tag, "_entry_pulse"}, pulse, 0);
    rc = 0;
  endtask

  task automatic stop_run(input string tag);
    enable = 1'b0;
    tick();
    chk({tag, "_stop_busy"}, busy, 0);
    chk({tag, "_stop_pulse"}, pulse, 0);
    chk({tag, "_stop_done"}, period_done, 0);
  endtask

  // One running clock of continuous mode against the model
  task automatic step(input string tag);
    bit ld;
    bit wrap;
    int np;
    int nd[CH];
    logic [CH-1:0] ep;
    ld = cfg_load;
    np = int'(period);
    for (int i = 0; i < CH; i++)
      nd[i] = int'(duty[i*W +: W]);
    ep = exp_pulse();
    wrap = (rp != 0) && (rc == rp - 1);
    tick();
    chk({tag, "_pulse"}, pulse, ep);
    chk({tag, "_done"}, period_done, wrap);
    chk({tag, "_busy"}, busy, 1);
    if (rp == 0) begin
      if (pv != 0) begin
        rp = pp;
        rd = pd;
        pv = 0;
      end
      if (ld) begin
        pp = np; pd = nd; pv = 1;
      end
    end else begin
      rc = wrap ? 0 : rc + 1;
      if (ld) begin
        pp = np; pd = nd; pv = 1;
      end
      if (wrap && pv != 0) begin
        rp = pp;
        rd = pd;
        pv = 0;
      end
    end
  endtask

  initial begin
    int p, n, at;
    rp = 0; rc = 0; pp = 0; pv = 0;
    for (int i = 0; i < CH; i++) begin
      rd[i] = 0;
      pd[i] = 0;
    end

    repeat (2) tick();
    chk("rst_pulse", pulse, 0);
    chk("rst_done", period_done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    // Continuous P=10, mixed duties incl. 0 and >=P
    idle_load(10, 3, 5, 0, 10);
    start_run("cont");
    repeat (35) step("cont");
    chk("cont_cnt_model", rc, 5);
    stop_run("drop");
    tick();
    chk("drop_no_done", period_done, 0);
    chk("drop_idle_busy", busy, 0);
    start_run("reen");
    repeat (12) step("reen");
    stop_run("reen");

    // Reconfiguration mid-period takes effect at the wrap
    idle_load(10, 3, 0, 0, 0);
    start_run("glitch");
    repeat (4) step("glitch_a");
    set_cfg(6, 2, 0, 0, 0);
    cfg_load = 1'b1;
    step("glitch_ld");
    cfg_load = 1'b0;
    repeat (5) step("glitch_old");
    chk("glitch_new_p", rp, 6);
    repeat (18) step("glitch_new");
    stop_run("glitch");

    // One-shot, launched twice
    idle_load(8, 4, 0, 0, 0);
    oneshot = 1'b1;
    enable  = 1'b1;
    tick();
    chk("os_wait_busy", busy, 0);
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("os_entry_busy", busy, 1);
      chk("os_entry_pulse", pulse, 0);
      for (int c = 0; c < 8; c++) begin
        tick();
        chk("os_pulse", pulse, (c < 7 && c < 4) ? 1 : 0);
        chk("os_done", period_done, (c == 7) ? 1 : 0);
        chk("os_busy", busy, (c < 7) ? 1 : 0);
      end
      tick();
      chk("os_after_done", period_done, 0);
      chk("os_after_busy", busy, 0);
    end
    enable  = 1'b0;
    oneshot = 1'b0;
    tick();

    // P=1: wrap every cycle
    idle_load(1, 1, 0, 0, 0);
    start_run("p1");
    repeat (6) step("p1");

    // Asynchronous reset while outputs are high
    #2 rst = 1'b0;
    #1;
    chk("arst_pulse", pulse, 0);
    chk("arst_done", period_done, 0);
    chk("arst_busy", busy, 0);
    enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("arst_rel_busy", busy, 0);
    chk("arst_rel_pulse", pulse, 0);
    rp = 0; rc = 0; pv = 0;
    for (int i = 0; i < CH; i++) rd[i] = 0;

    // P=0 after reset: held, silent; pending applied next cycle
    start_run("p0");
    repeat (5) step("p0");
    set_cfg(10, 3, 5, 0, 10);
    cfg_load = 1'b1;
    step("p0_ld");
    cfg_load = 1'b0;
    step("p0_apply");
    chk("p0_applied", rp, 10);
    repeat (12) step("p0_run");
    stop_run("p0");

    // Randomized runs with one reconfiguration at a random point
    for (int it = 0; it < 8; it++) begin
      p = $urandom_range(20, 1);
      idle_load(p, $urandom_range(24, 0), $urandom_range(24, 0),
                $urandom_range(24, 0), $urandom_range(24, 0));
      start_run("rnd");
      n  = 3 * p + 2;
      at = (it % 2 == 1) ? p - 1 : $urandom_range(n - 1, 0);
      for (int k = 0; k < n; k++) begin
        if (k == at) begin
          set_cfg($urandom_range(20, 1), $urandom_range(24, 0),
                  $urandom_range(24, 0), $urandom_range(24, 0),
                  $urandom_range(24, 0));
          cfg_load = 1'b1;
        end
        step("rnd");
        cfg_load = 1'b0;
      end
      stop_run("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
